// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the clk_div_gen clock-enable generator.
package clk_div_pkg;

  localparam int unsigned CLK_FREQ_HZ_DEF = 50_000_000;
  localparam int unsigned OUT_FREQ_HZ_DEF = 100;
  localparam int unsigned CNT_W_DEF       = 32;

  // Half-period in input clock cycles; 0 flags an unusable frequency pair.
  function automatic longint unsigned calc_half(input longint unsigned clk_hz,
                                                input longint unsigned out_hz);
    if (out_hz == 64'd0) return 64'd0;
    return clk_hz / (64'd2 * out_hz);
  endfunction

endpackage : clk_div_pkg

// File: rtl/clk_div_gen.sv
// Programmable clock-enable generator: slow square wave plus a one-cycle tick
// on each rising edge of it. Use tick as a clock enable; clk_out is for
// observation/pins only.
// Build option: define CLK_DIV_RUNTIME_EN to allow run-time reloading of the
// half-period through div_load/div_val (shadowed, applied at terminal count).
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
  parameter int unsigned OUT_FREQ_HZ = OUT_FREQ_HZ_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] half_cur
);

  localparam longint unsigned HALF_DEF_L =
    calc_half(64'(CLK_FREQ_HZ), 64'(OUT_FREQ_HZ));
  localparam logic [CNT_W-1:0] HALF_DEF = CNT_W'(HALF_DEF_L);

  // Reject default half-periods that are zero or do not fit the counter.
  generate
    if (HALF_DEF_L < 64'd1 ||
        (CNT_W < 64 && HALF_DEF_L >= (64'd1 << CNT_W))) begin : g_bad_half
      $error("clk_div_gen: default half-period out of range for CNT_W");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_act;
  logic             tc_c;

  // Terminal count: last cycle of the current half-period.
  assign tc_c = en & (cnt == half_act - CNT_W'(1));

  // Half-period counter, square-wave toggle and rising-edge tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (tc_c) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
      end else if (en) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef CLK_DIV_RUNTIME_EN
  logic [CNT_W-1:0] half_shd;
  logic             pend;

  // Shadowed reload: a new half-period is only adopted at terminal count so
  // the wave never produces a runt half; the last load before tc wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_act <= HALF_DEF;
      half_shd <= HALF_DEF;
      pend     <= 1'b0;
    end else begin
      if (tc_c && pend) begin
        half_act <= half_shd;
      end
      if (div_load) begin
        half_shd <= (div_val == '0) ? CNT_W'(1) : div_val;
        pend     <= 1'b1;
      end else if (tc_c && pend) begin
        pend <= 1'b0;
      end
    end
  end
`else
  logic unused_div;

  // Fixed half-period; reload pins kept only for pin compatibility.
  assign half_act   = HALF_DEF;
  assign unused_div = ^{div_load, div_val};
`endif

  assign half_cur = half_act;

endmodule : clk_div_gen

// File: doc/clk_div_gen.md
# clk_div_gen

Programmable clock-enable generator: derives a slow square wave and a single-cycle tick from the fast system clock (default 50 MHz → 100 Hz). It is the divide-down counterpart to the team's frequency-doubling clock benches. It feeds slow logic through `tick` as a clock enable, never as a clock. `clk_out` is for observation and off-chip pins only.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, input clock frequency.
- `OUT_FREQ_HZ`, 100, default output frequency.
- `CNT_W`, 32, width of the half-period counter and `div_val`.
- Derived constant `HALF_DEF` = `CLK_FREQ_HZ / (2*OUT_FREQ_HZ)`, integer division; 250_000 at defaults.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  count enable; low freezes all state.
- `div_load`  in  1  one-cycle strobe; captures `div_val`.
- `div_val`  in  CNT_W  new half-period, in `clk` cycles.
- `clk_out`  out  1  divided square wave, 50% duty.
- `tick`  out  1  one-cycle pulse per output period, coincident with `clk_out` rising.
- `half_cur`  out  CNT_W  half-period currently in force.

## Operation
- Registers:
  - `cnt` (CNT_W).
  - `half_act`: active half-period.
  - `half_shd`: shadow half-period.
  - `pend`: shadow-valid flag.
  - `clk_out` and `tick`.
- Terminal count `tc` = `en & (cnt == half_act-1)`.
- On `en=1` and not `tc`: `cnt <= cnt+1`.
- On `tc`:
  - `cnt <= 0`.
  - `clk_out <= ~clk_out`.
  - `tick <= ~clk_out`, so it is 1 only on a rising toggle.
  - If `pend`, then `half_act <= half_shd` and `pend <= 0`.
- `tick` is 0 on every cycle except the cycle after a rising `tc`.
- `en=0` holds `cnt`, `clk_out` and `half_act`, and forces `tick` to 0. `div_load` is still accepted while `en=0`.
- `div_load`:
  - `half_shd <= (div_val==0) ? 1 : div_val`, and `pend <= 1`.
  - The new value takes effect only at the next `tc`, so no runt pulses occur.
  - A later load before that `tc` overwrites the shadow; the last load wins.
- `div_load` on the same edge as `tc`: `tc` applies the old shadow (if pending), and the new value becomes pending for the following `tc`.
- `half_cur` = `half_act`.
- All arithmetic is unsigned in CNT_W bits. `cnt` never exceeds `half_act-1`, so no wrap-around.
- Elaboration error if `HALF_DEF < 1` or `HALF_DEF >= 2**CNT_W`.

## Timing
Reset values, applied on the first edge with `rst=1`:
- `cnt=0`, `clk_out=0`, `tick=0`.
- `half_act=HALF_DEF`, `half_shd=HALF_DEF`, `pend=0`.

`rst` overrides `en`, `div_load` and `tc` on the same edge. Reset mid-period discards the count and any pending load.

With `en` held at 1 from edge 1 after reset (H = `half_act`):
- `clk_out` rises after edge H and falls after edge 2H.
- The output period is 2H cycles.
- `tick` is high for the cycle starting after edge H, H+2H, H+4H, ….
- Latency from `en` rising to the first `tick` is H edges. Each edge with `en=0` adds one cycle.
- H=1 gives `clk_out` = clk/2 and `tick` high every other cycle.

## Configuration
- `CLK_DIV_RUNTIME_EN` defined: `div_load`/`div_val` behave as above.
- Not defined:
  - `div_load` and `div_val` are ignored; the ports remain for pin compatibility.
  - `half_shd` and `pend` are not built.
  - `half_act` is the constant `HALF_DEF`, and `half_cur` reports it.

## Structure
- Package `clk_div_pkg`:
  - function `calc_half(clk_hz, out_hz)`.
  - default constants `CLK_FREQ_HZ_DEF`, `OUT_FREQ_HZ_DEF`.
  - `CNT_W_DEF`.
- Single module; no sub-module. The counter and the toggle are too small to split.

## Test plan
All scenarios use `CLK_FREQ_HZ=1000`, `OUT_FREQ_HZ=100`, giving `HALF_DEF=5`.
- Reset, then `en=1` held: `clk_out` rises after edge 5 and falls after edge 10. `tick` is high exactly after edges 5, 15, 25. `half_cur=5`.
- `en=0` for 3 cycles at `cnt=2`: `clk_out` holds and `tick` stays 0. The next toggle is delayed by exactly 3 cycles.
- `div_load` with `div_val=2` at `cnt=1`: the current half completes at 5 cycles, then `clk_out` toggles every 2 cycles and `half_cur` changes to 2 at that `tc`.
- `div_load` with `div_val=0`: H=1 is applied at the next `tc`. After that, `clk_out` toggles every cycle and `tick` pulses every 2 cycles.
- `rst` asserted mid-period at `cnt=3` with `clk_out=1` and a pending load: the next cycle shows `clk_out=0`, `tick=0`, `half_cur=5`, and the pending load is discarded.
- Macro undefined, `div_load` with `div_val=2`: the period stays 10 cycles and `half_cur` stays 5.
